// File: rtl/lsu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : lsu_pkg                                                          |
// | Purpose : Shared LSU types and sizes. Holds the LDQ entry layout plus the  |
// |           memory-port arbiter's captured transaction and FSM state types.  |
// | Rev     : 1.0  initial memory-port arbiter types                           |
// +----------------------------------------------------------------------------+
package lsu_pkg;

  localparam int unsigned LDQ_ENTRIES = 8;
  localparam int unsigned SDQ_ENTRIES = 8;
  localparam int unsigned LDQ_IDX_W   = $clog2(LDQ_ENTRIES);
  localparam int unsigned LSU_ADDR_W  = 32;

  // One load as it sits in the load data queue.
  typedef struct packed {
    logic [LSU_ADDR_W-1:0] addr;
    logic [LDQ_IDX_W-1:0]  idx;
    logic [1:0]            size;
    logic                  sign_ext;
  } ldq_entry_t;

  // Transaction captured at grant and replayed on the memory port.
  typedef struct packed {
    logic                  we;
    logic [LSU_ADDR_W-1:0] addr;
    logic [31:0]           wdata;
    logic [3:0]            be;
    ldq_entry_t            ld;
  } mem_txn_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/lsu_mem_port_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : lsu_mem_port_arbiter_if                                        |
// | Purpose   : Bundles the LDQ issue, SDQ head, memory request/response and   |
// |             load writeback signals around the LSU memory-port arbiter.     |
// | Modports  : master - the arbiter; slave - LDQ/SDQ/memory/writeback side.   |
// | Signals   : ldq_pending, ldq_issue_en, ldq_issue_vld, ldq_issue_entry,     |
// |             sdq_head_vld, sdq_almost_full, sdq_head_addr/data/be,          |
// |             sdq_head_ack, mem_req_vld/rdy/we/addr/wdata/be,                |
// |             mem_resp_vld, mem_resp_rdata, ld_wb_vld/entry/data.            |
// | Rev       : 1.0  initial                                                   |
// +----------------------------------------------------------------------------+
interface lsu_mem_port_arbiter_if
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = LSU_ADDR_W
) ();

  logic              ldq_pending;
  logic              ldq_issue_en;
  logic              ldq_issue_vld;
  ldq_entry_t        ldq_issue_entry;

  logic              sdq_head_vld;
  logic              sdq_almost_full;
  logic [ADDR_W-1:0] sdq_head_addr;
  logic [31:0]       sdq_head_data;
  logic [3:0]        sdq_head_be;
  logic              sdq_head_ack;

  logic              mem_req_vld;
  logic              mem_req_rdy;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [31:0]       mem_req_wdata;
  logic [3:0]        mem_req_be;
  logic              mem_resp_vld;
  logic [31:0]       mem_resp_rdata;

  logic              ld_wb_vld;
  ldq_entry_t        ld_wb_entry;
  logic [31:0]       ld_wb_data;

  modport master (
    input  ldq_pending, ldq_issue_vld, ldq_issue_entry,
    input  sdq_head_vld, sdq_almost_full, sdq_head_addr, sdq_head_data, sdq_head_be,
    input  mem_req_rdy, mem_resp_vld, mem_resp_rdata,
    output ldq_issue_en, sdq_head_ack,
    output mem_req_vld, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be,
    output ld_wb_vld, ld_wb_entry, ld_wb_data
  );

  modport slave (
    output ldq_pending, ldq_issue_vld, ldq_issue_entry,
    output sdq_head_vld, sdq_almost_full, sdq_head_addr, sdq_head_data, sdq_head_be,
    output mem_req_rdy, mem_resp_vld, mem_resp_rdata,
    input  ldq_issue_en, sdq_head_ack,
    input  mem_req_vld, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be,
    input  ld_wb_vld, ld_wb_entry, ld_wb_data
  );

endinterface
`default_nettype wire

// File: rtl/lsu_arb_starve_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : lsu_arb_starve_ctr                                               |
// | Purpose : Saturating count of load grants taken while a store waits.       |
// |           clr has priority over inc; at_limit is high once the count       |
// |           reaches LIMIT and stays there until cleared.                     |
// | Ports   : clk, rst (async, active low), inc, clr, at_limit                 |
// | Rev     : 1.0  initial                                                     |
// +----------------------------------------------------------------------------+
module lsu_arb_starve_ctr #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int unsigned        c_cnt_w = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(LIMIT);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != c_limit)) begin
      r_cnt <= r_cnt + c_one;
    end
  end

  assign at_limit = (r_cnt == c_limit);

endmodule
`default_nettype wire

// File: rtl/lsu_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : lsu_mem_port_arbiter                                             |
// | Purpose : Shares the single LSU data-memory port between LDQ load issue    |
// |           and SDQ store drain. One transaction in flight: grant in IDLE,   |
// |           present the request in REQ until accepted, wait in RESP for the  |
// |           response, then pulse load writeback or the store ack.            |
// |           Loads win ties unless the SDQ is almost full, no load is pending |
// |           or STARVE_LIMIT loads have already passed a waiting store.       |
// | Ports   : clk, rst (async, active low), bus (lsu_mem_port_arbiter_if       |
// |           master modport).                                                 |
// |           With LSU_ARB_PERF_EN defined: perf_ld_grants, perf_st_grants,    |
// |           perf_stall_cycles (32-bit saturating counters).                  |
// | Rev     : 1.0  initial                                                     |
// +----------------------------------------------------------------------------+
module lsu_mem_port_arbiter
  import lsu_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ADDR_W       = LSU_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  lsu_mem_port_arbiter_if.master  bus
`ifdef LSU_ARB_PERF_EN
  ,
  output logic [31:0]             perf_ld_grants,
  output logic [31:0]             perf_st_grants,
  output logic [31:0]             perf_stall_cycles
`endif
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  mem_txn_t   r_txn;
  mem_txn_t   w_ld_txn;
  mem_txn_t   w_st_txn;

  logic w_idle;
  logic w_at_limit;
  logic w_st_pick;
  logic w_ld_grant;
  logic w_st_grant;
  logic w_issue_en;
  logic w_req_vld;
  logic w_wb_vld;
  logic w_st_ack;

  assign w_idle     = (r_state == IDLE);
  assign w_st_pick  = bus.sdq_head_vld &
                      (bus.sdq_almost_full | ~bus.ldq_pending | w_at_limit);
  // The LDQ only pops when its valid meets our enable, so grant on both.
  assign w_ld_grant = w_idle & ~w_st_pick & bus.ldq_issue_vld;
  assign w_st_grant = w_idle & w_st_pick;

  lsu_arb_starve_ctr #(
    .LIMIT    (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .inc      (w_ld_grant & bus.sdq_head_vld),
    .clr      (w_st_grant | (w_idle & ~bus.sdq_head_vld)),
    .at_limit (w_at_limit)
  );

  // Candidate transactions; the SDQ head is held until ack but is still
  // captured so the request never depends on the queue staying put.
  always_comb begin
    w_ld_txn       = '0;
    w_ld_txn.we    = 1'b0;
    w_ld_txn.addr  = bus.ldq_issue_entry.addr;
    w_ld_txn.be    = 4'hF;
    w_ld_txn.ld    = bus.ldq_issue_entry;

    w_st_txn       = '0;
    w_st_txn.we    = 1'b1;
    w_st_txn.addr  = bus.sdq_head_addr;
    w_st_txn.wdata = bus.sdq_head_data;
    w_st_txn.be    = bus.sdq_head_be;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_txn <= '0;
    end else if (w_ld_grant) begin
      r_txn <= w_ld_txn;
    end else if (w_st_grant) begin
      r_txn <= w_st_txn;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_ld_grant || w_st_grant) w_state_nxt = REQ;
      REQ:     if (bus.mem_req_rdy)          w_state_nxt = RESP;
      RESP:    if (bus.mem_resp_vld)         w_state_nxt = IDLE;
      default:                               w_state_nxt = IDLE;
    endcase
  end

  // FSM: outputs. Responses outside RESP are stale and must not leak out.
  always_comb begin
    w_issue_en = 1'b0;
    w_req_vld  = 1'b0;
    w_wb_vld   = 1'b0;
    w_st_ack   = 1'b0;
    unique case (r_state)
      IDLE: w_issue_en = ~w_st_pick;
      REQ:  w_req_vld  = 1'b1;
      RESP: begin
        w_wb_vld = bus.mem_resp_vld & ~r_txn.we;
        w_st_ack = bus.mem_resp_vld &  r_txn.we;
      end
      default: begin
        w_issue_en = 1'b0;
      end
    endcase
  end

  // Gated by rst so the enable stays low while reset is held.
  assign bus.ldq_issue_en  = w_issue_en & rst;
  assign bus.sdq_head_ack  = w_st_ack;
  assign bus.mem_req_vld   = w_req_vld;
  assign bus.mem_req_we    = w_req_vld & r_txn.we;
  assign bus.mem_req_addr  = w_req_vld ? r_txn.addr  : '0;
  assign bus.mem_req_wdata = w_req_vld ? r_txn.wdata : '0;
  assign bus.mem_req_be    = w_req_vld ? r_txn.be    : '0;
  assign bus.ld_wb_vld     = w_wb_vld;
  assign bus.ld_wb_entry   = w_wb_vld ? r_txn.ld : '0;
  assign bus.ld_wb_data    = w_wb_vld ? bus.mem_resp_rdata : '0;

`ifdef LSU_ARB_PERF_EN
  logic [31:0] r_perf_ld;
  logic [31:0] r_perf_st;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_ld    <= '0;
      r_perf_st    <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_ld_grant && (r_perf_ld != 32'hFFFF_FFFF)) begin
        r_perf_ld <= r_perf_ld + 32'd1;
      end
      if (w_st_grant && (r_perf_st != 32'hFFFF_FFFF)) begin
        r_perf_st <= r_perf_st + 32'd1;
      end
      if ((bus.ldq_pending || bus.sdq_head_vld) && !w_idle &&
          (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_ld_grants    = r_perf_ld;
  assign perf_st_grants    = r_perf_st;
  assign perf_stall_cycles = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_lsu_mem_port_arbiter                                          |
// | Purpose : Random LDQ/SDQ/memory traffic against lsu_mem_port_arbiter with  |
// |           a transaction-level reference model and a scoreboard monitor.    |
// | Rev     : 1.0  initial                                                     |
// +----------------------------------------------------------------------------+
module tb_lsu_mem_port_arbiter;
  import lsu_pkg::*;

  localparam int unsigned LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_port_arbiter_if #(.ADDR_W(32)) bus ();

  lsu_mem_port_arbiter #(
    .STARVE_LIMIT (LIMIT),
    .ADDR_W       (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] be; } store_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; } req_t;
  typedef struct { ldq_entry_t entry; logic [31:0] data; } wb_t;

  ldq_entry_t  ldq_q[$];
  store_t      sdq_q[$];
  req_t        exp_req[$];
  wb_t         exp_wb[$];
  logic [31:0] exp_ack[$];

  int checks   = 0;
  int failures = 0;

  // Reference model: 0 = port free, 1 = request waiting for accept,
  // 2 = request accepted, waiting for its response.
  int         txn_phase   = 0;
  bit         cur_is_load = 1'b0;
  ldq_entry_t cur_entry;
  int         waited_loads = 0;  // loads granted past the store now waiting

  int p_ld, p_st, p_af, p_rdy, p_resp, p_stale, p_ldv;
  bit          force_en    = 1'b0;
  logic [31:0] force_rdata = 32'h0;
  bit          starve_mode = 1'b0;
  bit          seen_store  = 1'b0;
  int          loads_since_store = 0;

  function automatic void check_eq(input string name, input logic [127:0] act,
                                   input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  function automatic bit chance(input int p);
    return $urandom_range(99) < p;
  endfunction

  function automatic ldq_entry_t rand_entry();
    ldq_entry_t e;
    e.addr     = $urandom;
    e.idx      = LDQ_IDX_W'($urandom_range(LDQ_ENTRIES - 1));
    e.size     = 2'($urandom_range(3));
    e.sign_ext = 1'($urandom_range(1));
    return e;
  endfunction

  function automatic store_t rand_store();
    store_t s;
    s.addr = $urandom;
    s.data = $urandom;
    s.be   = 4'($urandom_range(15));
    return s;
  endfunction

  task automatic drive_zero();
    bus.ldq_pending     = 1'b0;
    bus.ldq_issue_vld   = 1'b0;
    bus.ldq_issue_entry = '0;
    bus.sdq_head_vld    = 1'b0;
    bus.sdq_almost_full = 1'b0;
    bus.sdq_head_addr   = '0;
    bus.sdq_head_data   = '0;
    bus.sdq_head_be     = '0;
    bus.mem_req_rdy     = 1'b0;
    bus.mem_resp_vld    = 1'b0;
    bus.mem_resp_rdata  = '0;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_flags"},
             {bus.ldq_issue_en, bus.sdq_head_ack, bus.mem_req_vld, bus.mem_req_we, bus.ld_wb_vld}, '0);
    check_eq({tag, "_req"}, {bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_be}, '0);
    check_eq({tag, "_wb"}, {bus.ld_wb_entry, bus.ld_wb_data}, '0);
  endtask

  task automatic set_knobs(input int ld, st, af, rdy, resp, stale, ldv);
    p_ld = ld; p_st = st; p_af = af; p_rdy = rdy; p_resp = resp; p_stale = stale; p_ldv = ldv;
  endtask

  // One clock of stimulus plus the model's prediction for the coming edge.
  task automatic cycle();
    bit have_ld, have_st, af, st_pick, ld_vld, rdy, resp;
    ldq_entry_t e;
    store_t s;
    logic [31:0] rdata;
    @(negedge clk);
    if (chance(p_ld) && ldq_q.size() < LDQ_ENTRIES) ldq_q.push_back(rand_entry());
    if (chance(p_st) && sdq_q.size() < SDQ_ENTRIES) sdq_q.push_back(rand_store());
    have_ld = (ldq_q.size() != 0);
    have_st = (sdq_q.size() != 0);
    af      = chance(p_af);
    st_pick = have_st && (af || !have_ld || waited_loads >= LIMIT);
    ld_vld  = (txn_phase == 0) && have_ld && !st_pick && chance(p_ldv);
    rdy     = chance(p_rdy);
    resp    = (txn_phase == 2) ? chance(p_resp) : chance(p_stale);
    rdata   = force_en ? force_rdata : $urandom;
    s       = have_st ? sdq_q[0] : '{32'h0, 32'h0, 4'h0};

    bus.ldq_pending     = have_ld;
    bus.ldq_issue_vld   = ld_vld;
    bus.ldq_issue_entry = have_ld ? ldq_q[0] : '0;
    bus.sdq_head_vld    = have_st;
    bus.sdq_almost_full = af;
    bus.sdq_head_addr   = s.addr;
    bus.sdq_head_data   = s.data;
    bus.sdq_head_be     = s.be;
    bus.mem_req_rdy     = rdy;
    bus.mem_resp_vld    = resp;
    bus.mem_resp_rdata  = rdata;
    #1;
    check_eq("ldq_issue_en", bus.ldq_issue_en, (txn_phase == 0) && !st_pick);
    check_eq("mem_req_vld", bus.mem_req_vld, txn_phase == 1);

    case (txn_phase)
      0: begin
        if (ld_vld) begin
          e = ldq_q.pop_front();
          exp_req.push_back('{1'b0, e.addr, 32'h0, 4'hF});
          cur_is_load  = 1'b1;
          cur_entry    = e;
          waited_loads = have_st ? ((waited_loads < LIMIT) ? waited_loads + 1 : LIMIT) : 0;
          loads_since_store++;
          txn_phase = 1;
        end else if (st_pick) begin
          exp_req.push_back('{1'b1, s.addr, s.data, s.be});
          cur_is_load  = 1'b0;
          waited_loads = 0;
          if (starve_mode) begin
            if (seen_store) check_eq("starve_run", loads_since_store, LIMIT);
            seen_store = 1'b1;
          end
          loads_since_store = 0;
          txn_phase = 1;
        end else if (!have_st) begin
          waited_loads = 0;
        end
      end
      1: if (rdy) txn_phase = 2;
      default: begin
        if (resp) begin
          if (cur_is_load) begin
            exp_wb.push_back('{cur_entry, rdata});
          end else begin
            exp_ack.push_back(sdq_q[0].addr);
            void'(sdq_q.pop_front());
          end
          txn_phase = 0;
        end
      end
    endcase
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Scoreboard monitor: compares whatever the DUT presents against the
  // oldest expectation the model queued.
  initial begin
    req_t r;
    wb_t  w;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      #2;
      if (rst === 1'b1) begin
        if (bus.mem_req_vld) begin
          if (exp_req.size() == 0) begin
            check_eq("unexpected_req", bus.mem_req_vld, 1'b0);
          end else begin
            r = exp_req[0];
            check_eq("mem_req", {bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_be},
                     {r.we, r.addr, r.wdata, r.be});
            if (bus.mem_req_rdy) void'(exp_req.pop_front());
          end
        end
        if (bus.ld_wb_vld) begin
          if (exp_wb.size() == 0) begin
            check_eq("unexpected_ld_wb", bus.ld_wb_vld, 1'b0);
          end else begin
            w = exp_wb.pop_front();
            check_eq("ld_wb", {bus.ld_wb_entry, bus.ld_wb_data}, {w.entry, w.data});
          end
        end
        if (bus.sdq_head_ack) begin
          if (exp_ack.size() == 0) begin
            check_eq("unexpected_st_ack", bus.sdq_head_ack, 1'b0);
          end else begin
            a = exp_ack.pop_front();
            check_eq("st_ack_addr", bus.sdq_head_addr, a);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ldq_entry_t e0;
    drive_zero();
    set_knobs(0, 0, 0, 100, 100, 0, 100);
    #2;
    check_quiet("reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Single load at 0x100 returning 0xDEADBEEF, then a lone store.
    e0 = rand_entry();
    e0.addr = 32'h100;
    ldq_q.push_back(e0);
    force_en = 1'b1;
    force_rdata = 32'hDEADBEEF;
    run(6);
    force_en = 1'b0;
    sdq_q.push_back('{32'h40, 32'h1234, 4'b0011});
    run(6);

    set_knobs(40, 25, 15, 60, 50, 20, 70);
    run(600);

    // Loads and a store always pending: store forced every LIMIT loads.
    set_knobs(100, 100, 0, 100, 100, 0, 100);
    starve_mode = 1'b1;
    seen_store  = 1'b0;
    run(90);
    starve_mode = 1'b0;

    // SDQ almost full: stores pre-empt pending loads.
    set_knobs(100, 50, 100, 100, 100, 0, 100);
    run(60);

    // Heavy backpressure on the request channel.
    set_knobs(40, 30, 10, 15, 60, 20, 80);
    run(200);

    // Reset while waiting for a response, then a stale response.
    set_knobs(100, 0, 0, 100, 0, 0, 100);
    for (int i = 0; i < 60 && txn_phase != 2; i++) cycle();
    check_eq("reach_resp", txn_phase, 2);
    @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_quiet("async_reset");
    bus.mem_resp_vld = 1'b1;
    #1;
    check_quiet("reset_resp");
    ldq_q.delete(); sdq_q.delete();
    exp_req.delete(); exp_wb.delete(); exp_ack.delete();
    txn_phase = 0; waited_loads = 0;
    repeat (2) @(negedge clk);
    drive_zero();
    bus.mem_resp_vld = 1'b1;
    rst = 1'b1;
    set_knobs(0, 0, 0, 100, 100, 100, 100);
    run(6);

    set_knobs(45, 35, 20, 70, 60, 15, 75);
    run(300);

    // Drain everything still queued.
    set_knobs(0, 0, 0, 100, 100, 0, 100);
    run(120);
    check_eq("drain_req", exp_req.size(), 0);
    check_eq("drain_wb", exp_wb.size(), 0);
    check_eq("drain_ack", exp_ack.size(), 0);
    check_eq("drain_queues", ldq_q.size() + sdq_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
